handshake_tx: RTL and testbench

HANDSHAKE_TX -- requirements
Module: handshake_tx

---
 rtl/handshake_tx.sv | 178 +++++++++++++++++
 tb/tb_handshake_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx.sv
// handshake_tx
// Builds and serialises one USB-style handshake packet: SYNC field, 8-bit PID
// (LSB first) and an EOP request. The output is pre-NRZI. Bits advance once
// per useClk cycle with checkData=1.
//
// Parameters
//   SYNC_LEN   SYNC field length in bit times (8 full speed .. 32 high speed)
//   EOP_BITS   EOP request duration in bit times (1..8)
//
// Ports
//   useClk      in   clock, all state changes on the rising edge
//   nReset      in   asynchronous active-low reset
//   checkData   in   bit-time enable
//   sendReq     in   request to send one handshake packet
//   pidSel      in   0=ACK 1=NAK 2=STALL 3=NYET, sampled with sendReq
//   abort       in   synchronous cancel of a packet in progress
//   ready       out  high in IDLE
//   txBit       out  serial bit, LSB first
//   OE_TX       out  line drive enable for the whole packet including EOP
//   callEop     out  EOP request to the line driver
//   done        out  one-clock pulse on normal completion
//   reqDropped  out  high in a cycle where sendReq cannot be accepted
module handshake_tx #(
  parameter int SYNC_LEN = 8,
  parameter int EOP_BITS = 3
) (
  input  logic       useClk,
  input  logic       nReset,
  input  logic       checkData,
  input  logic       sendReq,
  input  logic [1:0] pidSel,
  input  logic       abort,
  output logic       ready,
  output logic       txBit,
  output logic       OE_TX,
  output logic       callEop,
  output logic       done,
  output logic       reqDropped
);

  localparam int NUM_STATES = 4;
  localparam int STATE_W    = $clog2(NUM_STATES);

  // Largest value the bit counter ever holds: last SYNC index, last PID
  // index, or the EOP count, which runs one past the last EOP bit time.
  localparam int CNT_MAX_A = (SYNC_LEN - 1 > 7) ? SYNC_LEN - 1 : 7;
  localparam int CNT_MAX   = (CNT_MAX_A > EOP_BITS) ? CNT_MAX_A : EOP_BITS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] EOP_LAST  = CNT_W'(EOP_BITS);

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    PID  = 2'd2,
    EOP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       pid_q;
  logic             txBit_q;
  logic             oe_q;
  logic             callEop_q;
  logic             done_q;
  logic             ready_q;

  logic [7:0]       pidPattern;
  logic             canAccept;
  logic             accept;

  // PID byte with bit 0 sent first.
  always_comb begin
    pidPattern = 8'hD2;
    unique case (pidSel)
      2'd0: pidPattern = 8'hD2;
      2'd1: pidPattern = 8'h5A;
      2'd2: pidPattern = 8'h1E;
      2'd3: pidPattern = 8'h96;
      default: pidPattern = 8'hD2;
    endcase
  end

  // The done cycle is already IDLE, but a request there is refused so the
  // earliest new packet starts one clock after done.
  assign canAccept  = (state_q == IDLE) && !done_q;
  assign accept     = canAccept && sendReq && !abort;
  assign reqDropped = sendReq && !canAccept;

  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pid_q     <= '0;
      txBit_q   <= 1'b0;
      oe_q      <= 1'b0;
      callEop_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        txBit_q   <= 1'b0;
        oe_q      <= 1'b0;
        callEop_q <= 1'b0;
        ready_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Acceptance does not wait for a bit time.
            if (accept) begin
              pid_q   <= pidPattern;
              state_q <= SYNC;
              cnt_q   <= '0;
              ready_q <= 1'b0;
            end
          end
          SYNC: begin
            if (checkData) begin
              txBit_q <= (cnt_q == SYNC_LAST);
              oe_q    <= 1'b1;
              if (cnt_q == SYNC_LAST) begin
                state_q <= PID;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          PID: begin
            if (checkData) begin
              txBit_q <= pid_q[cnt_q[2:0]];
              if (cnt_q == PID_LAST) begin
                state_q <= EOP;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          EOP: begin
            // Counter values 0..EOP_BITS-1 drive the EOP request; the value
            // EOP_BITS is the closing bit time that releases the line.
            if (checkData) begin
              txBit_q <= 1'b0;
              if (cnt_q == EOP_LAST) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                oe_q      <= 1'b0;
                callEop_q <= 1'b0;
                done_q    <= 1'b1;
                ready_q   <= 1'b1;
              end else begin
                callEop_q <= 1'b1;
                cnt_q     <= cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ready   = ready_q;
  assign txBit   = txBit_q;
  assign OE_TX   = oe_q;
  assign callEop = callEop_q;
  assign done    = done_q;

endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx
// Directed bench for handshake_tx: one instance with the default 8-bit SYNC
// and one with a 32-bit SYNC. Expected outputs come from a small timeline
// model indexed by the number of checkData edges since acceptance.
module tb_handshake_tx;

  logic       useClk;
  logic       nReset;
  logic       checkData;
  logic       sendReq8;
  logic       sendReq32;
  logic [1:0] pidSel;
  logic       abort;

  logic ready8, txBit8, oe8, callEop8, done8, reqDropped8;
  logic ready32, txBit32, oe32, callEop32, done32, reqDropped32;

  int total;
  int bad;

  logic [0:7] pidSeq [4];

  handshake_tx #(.SYNC_LEN(8), .EOP_BITS(3)) dut8 (
    .useClk     (useClk),
    .nReset     (nReset),
    .checkData  (checkData),
    .sendReq    (sendReq8),
    .pidSel     (pidSel),
    .abort      (abort),
    .ready      (ready8),
    .txBit      (txBit8),
    .OE_TX      (oe8),
    .callEop    (callEop8),
    .done       (done8),
    .reqDropped (reqDropped8)
  );

  handshake_tx #(.SYNC_LEN(32), .EOP_BITS(3)) dut32 (
    .useClk     (useClk),
    .nReset     (nReset),
    .checkData  (checkData),
    .sendReq    (sendReq32),
    .pidSel     (pidSel),
    .abort      (abort),
    .ready      (ready32),
    .txBit      (txBit32),
    .OE_TX      (oe32),
    .callEop    (callEop32),
    .done       (done32),
    .reqDropped (reqDropped32)
  );

  // 10 ns clock period.
  initial useClk = 1'b0;
  always #5 useClk = ~useClk;

  // Expected {txBit, OE_TX, callEop, done, ready} after the n-th checkData
  // edge since acceptance (n=0 is the acceptance edge itself), EOP of 3.
  function automatic logic [4:0] model(input int n, input int syncLen, input int p);
    logic [0:7] seq;
    seq = pidSeq[p];
    if (n == 0)                    return 5'b00000;
    else if (n < syncLen)          return 5'b01000;
    else if (n == syncLen)         return 5'b11000;
    else if (n <= syncLen + 8)     return {seq[n - syncLen - 1], 4'b1000};
    else if (n <= syncLen + 11)    return 5'b01100;
    else                           return 5'b00011;
  endfunction

  task automatic applyStimulus(input logic cd, input logic req8, input logic req32,
                               input logic [1:0] sel, input logic ab);
    checkData = cd;
    sendReq8  = req8;
    sendReq32 = req32;
    pidSel    = sel;
    abort     = ab;
  endtask

  task automatic tick();
    @(posedge useClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] vec8();
    return {3'b000, txBit8, oe8, callEop8, done8, ready8};
  endfunction

  function automatic logic [7:0] vec32();
    return {3'b000, txBit32, oe32, callEop32, done32, ready32};
  endfunction

  // Accept a packet on dut8 with checkData every cycle and check all 20 bit
  // times through the done pulse.
  task automatic runPacket8(input string name, input int p);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'(p), 1'b0);
    tick();
    checkOutput($sformatf("%s accept", name), vec8(), {3'b000, model(0, 8, p)});
    applyStimulus(1'b1, 1'b0, 1'b0, 2'(p), 1'b0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      checkOutput($sformatf("%s n=%0d", name, n), vec8(), {3'b000, model(n, 8, p)});
    end
    tick();
    checkOutput($sformatf("%s after done", name), vec8(), 8'b0000_0001);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pidSeq[0] = 8'b01001011;
    pidSeq[1] = 8'b01011010;
    pidSeq[2] = 8'b01111000;
    pidSeq[3] = 8'b01101001;

    // Reset state.
    nReset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset dut8", vec8(), 8'b0000_0001);
    checkOutput("reset dut32", vec32(), 8'b0000_0001);
    checkOutput("reset reqDropped", {6'b0, reqDropped8, reqDropped32}, 8'b0);
    nReset = 1'b1;
    tick();

    // Basic ACK packet at 8-bit SYNC.
    $display("[TB] ACK packet, SYNC_LEN=8");
    runPacket8("ack8", 0);

    // STALL at 32-bit SYNC with checkData one cycle in four.
    $display("[TB] STALL packet, SYNC_LEN=32, sparse checkData");
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    checkOutput("stall32 accept", vec32(), {3'b000, model(0, 32, 2)});
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    for (int n = 1; n <= 44; n++) begin
      for (int j = 0; j < 3; j++) begin
        checkData = 1'b0;
        tick();
        checkOutput($sformatf("stall32 hold n=%0d j=%0d", n, j), vec32(),
                    {3'b000, model(n - 1, 32, 2)});
      end
      checkData = 1'b1;
      tick();
      checkOutput($sformatf("stall32 n=%0d", n), vec32(), {3'b000, model(n, 32, 2)});
    end
    checkData = 1'b0;
    tick();
    checkOutput("stall32 after done", vec32(), 8'b0000_0001);

    // Abort in PID state, then a NAK goes out cleanly.
    $display("[TB] abort during PID");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int n = 1; n <= 11; n++) tick();
    checkOutput("abort pre", vec8(), {3'b000, model(11, 8, 0)});
    abort = 1'b1;
    tick();
    checkOutput("abort edge", vec8(), 8'b0000_0001);
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("abort idle k=%0d", k), vec8(), 8'b0000_0001);
    end
    runPacket8("nak8", 1);

    // Requests during SYNC and in the done cycle are dropped.
    $display("[TB] dropped requests");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    checkOutput("drop sync reqDropped", {7'b0, reqDropped8}, 8'd1);
    tick();
    checkOutput("drop sync n=3", vec8(), {3'b000, model(3, 8, 3)});
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    checkOutput("drop sync released", {7'b0, reqDropped8}, 8'd0);
    for (int n = 4; n <= 20; n++) begin
      tick();
      checkOutput($sformatf("nyet8 n=%0d", n), vec8(), {3'b000, model(n, 8, 3)});
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    #1;
    checkOutput("drop done reqDropped", {7'b0, reqDropped8}, 8'd1);
    tick();
    checkOutput("drop done not accepted", vec8(), 8'b0000_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();

    // Asynchronous reset during EOP.
    $display("[TB] reset during EOP");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int n = 1; n <= 18; n++) tick();
    checkOutput("eop pre reset", vec8(), {3'b000, model(18, 8, 0)});
    nReset = 1'b0;
    #1;
    checkOutput("async reset", vec8(), 8'b0000_0001);
    checkOutput("async reset reqDropped", {7'b0, reqDropped8}, 8'd0);
    #2;
    nReset = 1'b1;
    tick();
    checkOutput("after reset release", vec8(), 8'b0000_0001);
    runPacket8("ack8 again", 0);

    // checkData held low after acceptance stalls the packet in SYNC.
    $display("[TB] checkData held low");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("stall cd low k=%0d", k), vec8(), 8'b0000_0000);
    end
    checkData = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checkOutput($sformatf("resume nak8 n=%0d", n), vec8(), {3'b000, model(n, 8, 1)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
